// File: rtl/universal_shift_reg_pkg.sv
// Shared mode codes for the universal shift register.
// The enum values are the 3-bit encodings driven on the mode select input.
package universal_shift_reg_pkg;

  typedef enum logic [2:0] {
    MODE_HOLD = 3'b000,
    MODE_LOAD = 3'b001,
    MODE_SHL  = 3'b010,
    MODE_SHR  = 3'b011,
    MODE_ROL  = 3'b100,
    MODE_ROR  = 3'b101,
    MODE_ASR  = 3'b110,
    MODE_CLR  = 3'b111
  } mode_e;

  localparam int unsigned WIDTH_MIN = 2;
  localparam int unsigned WIDTH_MAX = 32;

endpackage

// File: rtl/universal_shift_reg_dff_vec.sv
// WIDTH-bit edge-triggered register with clock enable, synchronous reset
// value and true/complement outputs.
module dff_vec #(
  parameter int unsigned     WIDTH     = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             en_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o,
  output logic [WIDTH-1:0] qn_o
);

  logic [WIDTH-1:0] q_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      q_q <= RESET_VAL;
    end else if (en_i) begin
      q_q <= d_i;
    end
  end

  // Complement derives from the stored value, so it can never disagree with Q.
  assign q_o  = q_q;
  assign qn_o = ~q_q;

endmodule

// File: rtl/universal_shift_reg.sv
// Universal WIDTH-bit register: hold, load, shifts, rotates and clear,
// with serial-out flops recording the last bit shifted out each way.
module universal_shift_reg
  import universal_shift_reg_pkg::*;
#(
  parameter int unsigned      WIDTH     = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             EN,
  input  logic [2:0]       M,
  input  logic [WIDTH-1:0] D,
  input  logic             SI_L,
  input  logic             SI_R,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] Qn,
  output logic             SO_L,
  output logic             SO_R
);

  mode_e            mode;
  logic [WIDTH-1:0] q_d;
  logic             so_l_upd;
  logic             so_r_upd;
  logic             so_l_n_unused;
  logic             so_r_n_unused;

  assign mode = mode_e'(M);

  always_comb begin
    q_d      = Q;
    so_l_upd = 1'b0;
    so_r_upd = 1'b0;
    unique case (mode)
      MODE_HOLD: q_d = Q;
      MODE_LOAD: q_d = D;
      MODE_SHL: begin
        q_d      = {Q[WIDTH-2:0], SI_L};
        so_l_upd = 1'b1;
      end
      MODE_SHR: begin
        q_d      = {SI_R, Q[WIDTH-1:1]};
        so_r_upd = 1'b1;
      end
      MODE_ROL: begin
        q_d      = {Q[WIDTH-2:0], Q[WIDTH-1]};
        so_l_upd = 1'b1;
      end
      MODE_ROR: begin
        q_d      = {Q[0], Q[WIDTH-1:1]};
        so_r_upd = 1'b1;
      end
      MODE_ASR: begin
        q_d      = {Q[WIDTH-1], Q[WIDTH-1:1]};
        so_r_upd = 1'b1;
      end
      MODE_CLR: q_d = '0;
    endcase
  end

  dff_vec #(
    .WIDTH     (WIDTH),
    .RESET_VAL (RESET_VAL)
  ) u_q_reg (
    .clk_i (clk),
    .rst_i (rst),
    .en_i  (EN),
    .d_i   (q_d),
    .q_o   (Q),
    .qn_o  (Qn)
  );

  // Serial-out flops capture the departing end bit only on the modes that shift that way.
  dff_vec #(
    .WIDTH     (1),
    .RESET_VAL (1'b0)
  ) u_so_l_reg (
    .clk_i (clk),
    .rst_i (rst),
    .en_i  (EN & so_l_upd),
    .d_i   (Q[WIDTH-1]),
    .q_o   (SO_L),
    .qn_o  (so_l_n_unused)
  );

  dff_vec #(
    .WIDTH     (1),
    .RESET_VAL (1'b0)
  ) u_so_r_reg (
    .clk_i (clk),
    .rst_i (rst),
    .en_i  (EN & so_r_upd),
    .d_i   (Q[0]),
    .q_o   (SO_R),
    .qn_o  (so_r_n_unused)
  );

endmodule

// File: tb/tb_universal_shift_reg.sv
// Self-checking bench for universal_shift_reg at WIDTH 8, 2 and 32, with a
// per-width arithmetic reference model plus directed literal checks.
module tb_universal_shift_reg;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en  = 1'b0;
  logic [2:0]  m   = 3'b000;
  logic [31:0] d   = '0;
  logic        sil = 1'b0;
  logic        sir = 1'b0;

  logic [7:0]  q8,  qn8;
  logic [1:0]  q2,  qn2;
  logic [31:0] q32, qn32;
  logic        sol8, sor8, sol2, sor2, sol32, sor32;

  int n_tests = 0;
  int n_fail  = 0;

  localparam logic [2:0] HOLD = 3'd0, LOAD = 3'd1, SHL = 3'd2, SHR = 3'd3,
                         ROL = 3'd4, ROR = 3'd5, ASR = 3'd6, CLR = 3'd7;

  always #5 clk = ~clk;

  universal_shift_reg #(.WIDTH(8), .RESET_VAL(8'hA5)) dut8 (
    .clk(clk), .rst(rst), .EN(en), .M(m), .D(d[7:0]), .SI_L(sil), .SI_R(sir),
    .Q(q8), .Qn(qn8), .SO_L(sol8), .SO_R(sor8));

  universal_shift_reg #(.WIDTH(2), .RESET_VAL(2'b00)) dut2 (
    .clk(clk), .rst(rst), .EN(en), .M(m), .D(d[1:0]), .SI_L(sil), .SI_R(sir),
    .Q(q2), .Qn(qn2), .SO_L(sol2), .SO_R(sor2));

  universal_shift_reg #(.WIDTH(32), .RESET_VAL(32'h0)) dut32 (
    .clk(clk), .rst(rst), .EN(en), .M(m), .D(d), .SI_L(sil), .SI_R(sir),
    .Q(q32), .Qn(qn32), .SO_L(sol32), .SO_R(sor32));

  // Reference model: one slot per instance, values kept in 32-bit words.
  int          mw   [3] = '{8, 2, 32};
  logic [31:0] mrst [3] = '{32'hA5, 32'h0, 32'h0};
  logic [31:0] mq   [3];
  logic        msol [3];
  logic        msor [3];
  bit          mvalid = 1'b0;

  function automatic logic [31:0] wmask(int w);
    return (w == 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
  endfunction

  always @(posedge clk) begin
    for (int k = 0; k < 3; k++) begin
      int          w;
      logic [31:0] msk, q, msb;
      w   = mw[k];
      msk = wmask(w);
      q   = mq[k];
      msb = 32'd1 << (w - 1);
      if (rst) begin
        mq[k] = mrst[k]; msol[k] = 1'b0; msor[k] = 1'b0;
      end else if (en && mvalid) begin
        case (m)
          LOAD: mq[k] = d & msk;
          SHL:  begin mq[k] = ((q << 1) | 32'(sil)) & msk;      msol[k] = (q & msb) != 0; end
          SHR:  begin mq[k] = (q >> 1) | (sir ? msb : 32'd0);   msor[k] = q[0]; end
          ROL:  begin mq[k] = ((q << 1) | (q >> (w - 1))) & msk; msol[k] = (q & msb) != 0; end
          ROR:  begin mq[k] = (q >> 1) | (q[0] ? msb : 32'd0);   msor[k] = q[0]; end
          ASR:  begin mq[k] = (q >> 1) | (q & msb);              msor[k] = q[0]; end
          CLR:  mq[k] = 32'd0;
          default: ;
        endcase
      end
    end
    if (rst) mvalid = 1'b1;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (mvalid) begin
      chk("m8.Q",    {24'b0, q8},   mq[0]);
      chk("m8.Qn",   {24'b0, qn8},  ~mq[0] & wmask(8));
      chk("m8.SO_L", {31'b0, sol8}, {31'b0, msol[0]});
      chk("m8.SO_R", {31'b0, sor8}, {31'b0, msor[0]});
      chk("m2.Q",    {30'b0, q2},   mq[1]);
      chk("m2.Qn",   {30'b0, qn2},  ~mq[1] & wmask(2));
      chk("m2.SO_L", {31'b0, sol2}, {31'b0, msol[1]});
      chk("m2.SO_R", {31'b0, sor2}, {31'b0, msor[1]});
      chk("m32.Q",   q32,           mq[2]);
      chk("m32.Qn",  qn32,          ~mq[2]);
      chk("m32.SO_L",{31'b0, sol32},{31'b0, msol[2]});
      chk("m32.SO_R",{31'b0, sor32},{31'b0, msor[2]});
    end
  end

  task automatic step(input logic [2:0] mode, input int n = 1);
    m  = mode;
    en = 1'b1;
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic load8(input logic [31:0] v);
    d = v;
    step(LOAD);
  endtask

  initial begin
    // Reset with EN low, then reset against an enabled LOAD.
    rst = 1'b1; en = 1'b0;
    @(posedge clk); #1;
    chk("rst.Q",    {24'b0, q8},  32'hA5);
    chk("rst.Qn",   {24'b0, qn8}, 32'h5A);
    chk("rst.SO",   {30'b0, sol8, sor8}, 32'h0);
    chk("rst.Q32",  q32,  32'h0);
    chk("rst.Qn32", qn32, 32'hFFFF_FFFF);
    d = 32'hFFFF_FFFF;
    step(LOAD);
    chk("rst_wins.Q", {24'b0, q8}, 32'hA5);
    rst = 1'b0;

    // Load and hold with D and serial inputs wiggling while disabled.
    load8(32'h3C);
    chk("load.Q", {24'b0, q8}, 32'h3C);
    en = 1'b0; m = LOAD;
    for (int i = 0; i < 3; i++) begin
      d = 32'hFFFF_FFFF ^ i; sil = i[0]; sir = ~i[0];
      @(posedge clk); #1;
    end
    chk("hold_en0.Q", {24'b0, q8}, 32'h3C);

    // Shift left then right.
    load8(32'h81);
    sil = 1'b0; step(SHL);
    chk("shl.Q",    {24'b0, q8}, 32'h02);
    chk("shl.SO_L", {31'b0, sol8}, 32'h1);
    sir = 1'b1; step(SHR);
    chk("shr.Q",    {24'b0, q8}, 32'h81);
    chk("shr.SO_R", {31'b0, sor8}, 32'h0);

    // Full rotations restore the value.
    load8(32'h96);
    step(ROL, 8);
    chk("rol8.Q", {24'b0, q8}, 32'h96);
    step(ROR, 8);
    chk("ror8.Q", {24'b0, q8}, 32'h96);

    // Arithmetic shift right.
    load8(32'h80);
    step(ASR, 3);
    chk("asr3.Q",    {24'b0, q8}, 32'hF0);
    chk("asr3.SO_R", {31'b0, sor8}, 32'h0);
    load8(32'hFF);
    step(ASR, 2);
    chk("asr_ones.Q", {24'b0, q8}, 32'hFF);

    // Clear leaves serial outputs alone; HOLD changes nothing.
    load8(32'h81);
    sil = 1'b0; step(SHL);
    step(CLR);
    chk("clr.Q",    {24'b0, q8}, 32'h00);
    chk("clr.SO_L", {31'b0, sol8}, 32'h1);
    step(HOLD, 2);
    chk("hold.Q",    {24'b0, q8}, 32'h00);
    chk("hold.SO_L", {31'b0, sol8}, 32'h1);

    // Reset in the middle of a sequence restarts from the reset value.
    load8(32'h3C);
    step(SHL);
    rst = 1'b1; step(SHL);
    chk("midrst.Q", {24'b0, q8}, 32'hA5);
    rst = 1'b0; sil = 1'b0; step(SHL);
    chk("midrst_shl.Q",    {24'b0, q8}, 32'h4A);
    chk("midrst_shl.SO_L", {31'b0, sol8}, 32'h1);

    // Width sweep: all ones shifted out with zeros.
    load8(32'hFFFF_FFFF);
    chk("ones.Q2",  {30'b0, q2}, 32'h3);
    chk("ones.Q32", q32, 32'hFFFF_FFFF);
    sil = 1'b0;
    for (int i = 1; i <= 32; i++) begin
      step(SHL);
      if (i <= 2) chk("sweep2.SO_L", {31'b0, sol2}, 32'h1);
      chk("sweep32.SO_L", {31'b0, sol32}, 32'h1);
      if (i == 2) begin
        chk("sweep2.Q",  {30'b0, q2},  32'h0);
        chk("sweep2.Qn", {30'b0, qn2}, 32'h3);
      end
    end
    chk("sweep32.Q",  q32,  32'h0);
    chk("sweep32.Qn", qn32, 32'hFFFF_FFFF);

    en = 1'b0;
    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
